// File: rtl/floo_reduction_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : floo_reduction_engine                                        |
// | Description : Gathers the flits of one collective reduction from several   |
// |               input routes, combines them lane-wise with a selectable      |
// |               operator and emits one registered result flit. A timeout     |
// |               emits a partial (error-flagged) result instead of blocking.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module floo_reduction_engine #(
  parameter int unsigned NumRoutes     = 5,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned LaneWidth     = 16,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumRoutes-1:0]           valid_i,
  output logic [NumRoutes-1:0]           ready_o,
  input  logic [NumRoutes*DataWidth-1:0] data_i,
  input  logic [NumRoutes*NumRoutes-1:0] mask_i,
  input  logic [NumRoutes*3-1:0]         op_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DataWidth-1:0]           data_o,
  output logic                           err_o,
  output logic                           busy_o
);

  localparam int unsigned NumLanes = DataWidth / LaneWidth;
  localparam int unsigned IdxWidth = $clog2(NumRoutes);
  // A disabled timeout yields a zero-width counter; keep at least one bit.
  localparam int unsigned CW       = (CntWidth < 1) ? 1 : CntWidth;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_MIN = 3'd1;
  localparam logic [2:0] c_OP_MAX = 3'd2;
  localparam logic [2:0] c_OP_AND = 3'd3;
  localparam logic [2:0] c_OP_OR  = 3'd4;
  localparam logic [2:0] c_OP_XOR = 3'd5;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IdxWidth-1:0]  leader_q, leader_d;
  logic [NumRoutes-1:0] mask_q, mask_d;
  logic [2:0]           op_q, op_d;

  logic                 valid_q, err_q;
  logic [DataWidth-1:0] data_q;

  logic [IdxWidth-1:0]  w_lead_idx;
  logic                 w_lead_vld;
  logic [NumRoutes-1:0] w_row_mask;
  logic [2:0]           w_row_op;
  logic [IdxWidth-1:0]  w_act_idx;
  logic [NumRoutes-1:0] w_act_mask;
  logic [2:0]           w_act_op;
  logic [NumRoutes-1:0] w_present;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_free;
  logic                 w_fire;
  logic [DataWidth-1:0] w_lead_data;
  logic [DataWidth-1:0] w_result;
  logic [LaneWidth-1:0] w_acc;
  logic [LaneWidth-1:0] w_val;
  logic                 w_first;

  // Leader = lowest-index valid route; fetch its mask row and operator.
  always_comb begin
    w_lead_idx = '0;
    w_lead_vld = 1'b0;
    w_row_mask = '0;
    w_row_op   = '0;
    for (int r = NumRoutes - 1; r >= 0; r--) begin
      if (valid_i[r]) begin
        w_lead_idx = IdxWidth'(r);
        w_lead_vld = 1'b1;
      end
    end
    for (int r = 0; r < NumRoutes; r++) begin
      if (IdxWidth'(r) == w_lead_idx) begin
        w_row_mask = mask_i[r*NumRoutes +: NumRoutes];
        w_row_op   = op_i[r*3 +: 3];
      end
    end
  end

  // While waiting, the reduction is governed by what was latched at entry.
  always_comb begin
    w_act_idx  = (state_q == c_WAIT) ? leader_q : w_lead_idx;
    w_act_mask = (state_q == c_WAIT) ? mask_q   : w_row_mask;
    w_act_op   = (state_q == c_WAIT) ? op_q     : w_row_op;
    w_present  = valid_i & w_act_mask;
    w_complete = ((state_q == c_WAIT) || w_lead_vld) && (w_present == w_act_mask);
    w_timeout  = (TimeoutCycles != 0) && (state_q == c_WAIT) &&
                 (cnt_q == CW'(TimeoutCycles));
    w_free     = !valid_q || ready_i;
    w_fire     = w_free && (w_complete || w_timeout);
    ready_o    = w_fire ? w_present : '0;
  end

  // Lane-wise reduction over the present contributors in ascending order.
  always_comb begin
    w_lead_data = '0;
    w_result    = '0;
    w_acc       = '0;
    w_val       = '0;
    w_first     = 1'b1;
    for (int r = 0; r < NumRoutes; r++) begin
      if (IdxWidth'(r) == w_act_idx) w_lead_data = data_i[r*DataWidth +: DataWidth];
    end
    for (int l = 0; l < NumLanes; l++) begin
      w_acc   = '0;
      w_first = 1'b1;
      for (int r = 0; r < NumRoutes; r++) begin
        if (w_present[r]) begin
          w_val = data_i[r*DataWidth + l*LaneWidth +: LaneWidth];
          if (w_first) begin
            w_acc   = w_val;
            w_first = 1'b0;
          end else begin
            case (w_act_op)
              c_OP_ADD: w_acc = w_acc + w_val;
              c_OP_MIN: if ($signed(w_val) < $signed(w_acc)) w_acc = w_val;
              c_OP_MAX: if ($signed(w_val) > $signed(w_acc)) w_acc = w_val;
              c_OP_AND: w_acc = w_acc & w_val;
              c_OP_OR:  w_acc = w_acc | w_val;
              c_OP_XOR: w_acc = w_acc ^ w_val;
              default:  w_acc = w_acc;
            endcase
          end
        end
      end
      if (w_act_op > c_OP_XOR) w_acc = w_lead_data[l*LaneWidth +: LaneWidth];
      w_result[l*LaneWidth +: LaneWidth] = w_acc;
    end
  end

  // Next-state logic: enter WAIT on an incomplete leader, count, fire or time out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    leader_d = leader_q;
    mask_d   = mask_q;
    op_d     = op_q;
    case (state_q)
      c_IDLE: begin
        if (w_lead_vld && !w_complete) begin
          state_d  = c_WAIT;
          cnt_d    = CW'(1);
          leader_d = w_lead_idx;
          mask_d   = w_row_mask;
          op_d     = w_row_op;
        end
      end
      c_WAIT: begin
        if (w_fire) begin
          state_d = c_IDLE;
          cnt_d   = '0;
        end else if (!w_complete && (cnt_q < CW'(TimeoutCycles))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Reduction tracking state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= c_IDLE;
      cnt_q    <= '0;
      leader_q <= '0;
      mask_q   <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      leader_q <= leader_d;
      mask_q   <= mask_d;
      op_q     <= op_d;
    end
  end

  // Output stage: loads on fire, holds under backpressure, drains on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else if (w_fire) begin
      valid_q <= 1'b1;
      err_q   <= !w_complete;
      data_q  <= w_result;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q == c_WAIT);

  // The leader must not change while its reduction is outstanding.
  a_stable_leader : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == c_WAIT) && w_lead_vld) |-> (w_lead_idx == leader_q));

endmodule
`default_nettype wire

// File: tb/tb_floo_reduction_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_floo_reduction_engine                                     |
// | Description : Self-checking bench for floo_reduction_engine; expected      |
// |               results are queued at fire time and popped on output.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_floo_reduction_engine;

  localparam int NR = 5;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int NL = DW / LW;
  localparam int TO = 8;

  localparam logic [2:0] c_ADD = 3'd0, c_MIN = 3'd1, c_MAX = 3'd2;
  localparam logic [2:0] c_AND = 3'd3, c_OR = 3'd4, c_XOR = 3'd5, c_SEL = 3'd6;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     vld;
  logic [DW-1:0]     dat [NR];
  logic [NR-1:0]     msk [NR];
  logic [2:0]        opr [NR];
  logic [NR*DW-1:0]  data_i;
  logic [NR*NR-1:0]  mask_i;
  logic [NR*3-1:0]   op_i;
  logic [NR-1:0]     ready_o;
  logic              valid_o, ready_i, err_o, busy_o;
  logic [DW-1:0]     data_o;

  res_t sb[$];
  res_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    data_i = '0;
    mask_i = '0;
    op_i   = '0;
    for (int r = 0; r < NR; r++) begin
      data_i[r*DW +: DW] = dat[r];
      mask_i[r*NR +: NR] = msk[r];
      op_i[r*3 +: 3]     = opr[r];
    end
  end

  floo_reduction_engine #(
    .NumRoutes(NR), .DataWidth(DW), .LaneWidth(LW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vld), .ready_o(ready_o),
    .data_i(data_i), .mask_i(mask_i), .op_i(op_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .err_o(err_o), .busy_o(busy_o)
  );

  function automatic logic [DW-1:0] lanes(input logic [LW-1:0] v);
    return {NL{v}};
  endfunction

  // Reference reduction over contributors c in ascending route order.
  function automatic logic [DW-1:0] model(input logic [NR-1:0] c, input logic [2:0] op,
                                          input int ld);
    logic [DW-1:0] res;
    logic signed [LW-1:0] a, v;
    bit first;
    res = '0;
    for (int l = 0; l < NL; l++) begin
      a = '0;
      first = 1'b1;
      for (int r = 0; r < NR; r++) begin
        if (c[r]) begin
          v = dat[r][l*LW +: LW];
          if (first) begin a = v; first = 1'b0; end
          else if (op == c_ADD) a = a + v;
          else if (op == c_MIN) a = (v < a) ? v : a;
          else if (op == c_MAX) a = (v > a) ? v : a;
          else if (op == c_AND) a = a & v;
          else if (op == c_OR)  a = a | v;
          else if (op == c_XOR) a = a ^ v;
        end
      end
      if (op >= c_SEL) a = dat[ld][l*LW +: LW];
      res[l*LW +: LW] = a;
    end
    return res;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ready_i = 1'b1; vld = '0;
    for (int r = 0; r < NR; r++) begin
      dat[r] = '0; msk[r] = NR'(1) << r; opr[r] = c_ADD;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({valid_o, err_o, busy_o, ready_o, data_o} !== '0)
      $display("FAIL reset_state got v=%b e=%b b=%b r=%b d=%h want all zero",
               valid_o, err_o, busy_o, ready_o, data_o);
    else n_pass++;
  endtask

  task automatic test_add_wrap();
    @(posedge clk); #1;
    vld = 5'b00111; msk[0] = 5'b00111; opr[0] = c_ADD;
    dat[0] = lanes(16'h0001); dat[1] = lanes(16'h0002); dat[2] = lanes(16'hFFFF);
    sb.push_back('{err: 1'b0, data: model(5'b00111, c_ADD, 0)});
    @(negedge clk);
    n_checks++;
    if (ready_o !== 5'b00111 || valid_o !== 1'b0)
      $display("FAIL add_fire got ready=%b valid=%b want 00111/0", ready_o, valid_o);
    else n_pass++;
    @(posedge clk); #1 vld = '0;
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b1 || ready_o !== '0 || data_o !== lanes(16'h0002) || err_o !== 1'b0)
      $display("FAIL add_result got v=%b r=%b d=%h e=%b want 1/0/%h/0",
               valid_o, ready_o, data_o, err_o, lanes(16'h0002));
    else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL add_sb got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (data_o !== e.data || err_o !== e.err)
        $display("FAIL add_sb got %h/%b want %h/%b", data_o, err_o, e.data, e.err);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL add_drain got valid=%b want 0", valid_o);
    else n_pass++;
  endtask

  task automatic test_minmax();
    logic [2:0] ops [2];
    logic [LW-1:0] want [2];
    ops[0] = c_MIN; ops[1] = c_MAX; want[0] = 16'h8000; want[1] = 16'h7FFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vld = 5'b00011; msk[0] = 5'b00011; opr[0] = ops[i];
      dat[0] = lanes(16'h8000); dat[1] = lanes(16'h7FFF);
      sb.push_back('{err: 1'b0, data: model(5'b00011, ops[i], 0)});
      @(posedge clk); #1 vld = '0;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== lanes(want[i]))
        $display("FAIL minmax_%0d got v=%b d=%h want 1/%h", i, valid_o, data_o, lanes(want[i]));
      else n_pass++;
      n_checks++;
      if (sb.size() == 0) $display("FAIL minmax_sb got empty queue want entry");
      else begin
        e = sb.pop_front();
        if (data_o !== e.data || err_o !== e.err)
          $display("FAIL minmax_sb got %h/%b want %h/%b", data_o, err_o, e.data, e.err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout(input bit late);
    logic [NR-1:0] want_rdy;
    @(posedge clk); #1;
    vld = 5'b00001; msk[0] = 5'b00011; opr[0] = c_OR;
    dat[0] = lanes(16'h00F0); dat[1] = lanes(16'h0F00);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== '0)
      $display("FAIL to_start got busy=%b ready=%b want 0/0", busy_o, ready_o);
    else n_pass++;
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (late && k == TO) vld = 5'b00011;
      @(negedge clk);
      want_rdy = (k != TO) ? 5'b00000 : (late ? 5'b00011 : 5'b00001);
      n_checks++;
      if (busy_o !== 1'b1 || ready_o !== want_rdy)
        $display("FAIL to_wait_%0d got busy=%b ready=%b want 1/%b", k, busy_o, ready_o, want_rdy);
      else n_pass++;
      if (k == TO) sb.push_back('{err: !late, data: model(vld, c_OR, 0)});
    end
    @(posedge clk); #1 vld = '0;
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b0 || err_o !== !late ||
        data_o !== lanes(late ? 16'h0FF0 : 16'h00F0))
      $display("FAIL to_result late=%0d got v=%b b=%b e=%b d=%h", late, valid_o, busy_o, err_o, data_o);
    else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL to_sb got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (data_o !== e.data || err_o !== e.err)
        $display("FAIL to_sb got %h/%b want %h/%b", data_o, err_o, e.data, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    ready_i = 1'b0;
    vld = 5'b00011; msk[0] = 5'b00011; opr[0] = c_AND;
    dat[0] = lanes(16'hF0F0); dat[1] = lanes(16'hFF00);
    sb.push_back('{err: 1'b0, data: model(5'b00011, c_AND, 0)});
    @(negedge clk);
    n_checks++;
    if (ready_o !== 5'b00011) $display("FAIL bp_first got ready=%b want 00011", ready_o);
    else n_pass++;
    @(posedge clk); #1;
    dat[0] = lanes(16'h1234); dat[1] = lanes(16'h00FF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b1 || ready_o !== '0 || data_o !== lanes(16'hF000))
        $display("FAIL bp_hold_%0d got v=%b r=%b d=%h want 1/0/%h",
                 i, valid_o, ready_o, data_o, lanes(16'hF000));
      else n_pass++;
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 5'b00011) $display("FAIL bp_release got ready=%b want 00011", ready_o);
    else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL bp_sb_a got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || data_o !== e.data || err_o !== e.err)
        $display("FAIL bp_sb_a got %b/%h/%b want 1/%h/%b", valid_o, data_o, err_o, e.data, e.err);
      else n_pass++;
    end
    sb.push_back('{err: 1'b0, data: model(5'b00011, c_AND, 0)});
    @(posedge clk); #1 vld = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) $display("FAIL bp_sb_b got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || data_o !== e.data || data_o !== lanes(16'h0034))
        $display("FAIL bp_sb_b got %b/%h want 1/%h", valid_o, data_o, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vld = 5'b00111; msk[0] = 5'b00111; opr[0] = c_XOR;
      for (int r = 0; r < 3; r++) dat[r] = {$urandom, $urandom};
      sb.push_back('{err: 1'b0, data: model(5'b00111, c_XOR, 0)});
      @(negedge clk);
      n_checks++;
      if (ready_o !== 5'b00111) $display("FAIL b2b_ready_%0d got %b want 00111", i, ready_o);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL b2b_sb got empty queue want entry");
        else begin
          e = sb.pop_front();
          if (valid_o !== 1'b1 || data_o !== e.data || err_o !== 1'b0)
            $display("FAIL b2b_out_%0d got %b/%h/%b want 1/%h/0", i, valid_o, data_o, err_o, e.data);
          else n_pass++;
        end
      end
    end
    @(posedge clk); #1 vld = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) $display("FAIL b2b_last got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || data_o !== e.data)
        $display("FAIL b2b_last got %b/%h want 1/%h", valid_o, data_o, e.data);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL b2b_drain got valid=%b want 0", valid_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    ready_i = 1'b0;
    vld = 5'b00011; msk[0] = 5'b00011; opr[0] = c_ADD;
    @(posedge clk); #1 vld = 5'b00001;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b1)
      $display("FAIL ar_pre got busy=%b valid=%b want 1/1", busy_o, valid_o);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || ready_o !== '0)
      $display("FAIL ar_async got busy=%b valid=%b ready=%b want 0/0/0", busy_o, valid_o, ready_o);
    else n_pass++;
    vld = '0; ready_i = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL ar_release got busy=%b valid=%b want 0/0", busy_o, valid_o);
    else n_pass++;
    // SELECT with a non-zero leader after reset.
    @(posedge clk); #1;
    vld = 5'b01110; msk[1] = 5'b01110; opr[1] = c_SEL;
    for (int r = 1; r < 4; r++) dat[r] = {$urandom, $urandom};
    sb.push_back('{err: 1'b0, data: model(5'b01110, c_SEL, 1)});
    @(negedge clk);
    n_checks++;
    if (ready_o !== 5'b01110) $display("FAIL sel_ready got %b want 01110", ready_o);
    else n_pass++;
    @(posedge clk); #1 vld = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) $display("FAIL sel_sb got empty queue want entry");
    else begin
      e = sb.pop_front();
      if (valid_o !== 1'b1 || data_o !== e.data || data_o !== dat[1])
        $display("FAIL sel_out got %b/%h want 1/%h", valid_o, data_o, dat[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_minmax();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
